// File: rtl/conv_result_streamer.sv
// Streams the Sobel magnitude map out of the result BRAM as a valid/ready byte stream,
// with optional binarization and an edge-pixel counter for software readback.
module conv_result_streamer #(
    parameter int unsigned OUT_WIDTH  = 30,
    parameter int unsigned OUT_HEIGHT = 30,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        done,
    input  logic [7:0]  threshold,
    input  logic        bin_en,
    output logic [31:0] bram_addr,
    output logic        bram_en,
    input  logic [31:0] bram_dout,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [15:0] edge_count
);

    localparam int unsigned N     = OUT_WIDTH * OUT_HEIGHT;
    localparam int unsigned IDX_W = $clog2(N + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CRD_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   start_xfer;

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] beat_cnt;
    logic             rd_valid;
    logic [7:0]       thr_q;
    logic             bin_q;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    logic [7:0]       head;
    logic [CRD_W-1:0] credit;
    logic             issue;
    logic             push;
    logic             pop;
    logic             unused_dout_bits;

    assign unused_dout_bits = ^bram_dout[31:8];

    assign head     = fifo_mem[rd_ptr];
    assign m_tvalid = (fifo_count != '0);
    assign m_tlast  = m_tvalid && (beat_cnt == IDX_W'(N - 1));
    assign m_tdata  = bin_q ? ((head >= thr_q) ? 8'hFF : 8'h00) : head;

    // Credit covers FIFO occupancy plus the two read pipeline stages, so every read has a slot.
    assign credit = CRD_W'(fifo_count) + CRD_W'(bram_en) + CRD_W'(rd_valid);
    assign issue  = (state == RUN) && (rd_idx < IDX_W'(N)) && (credit < CRD_W'(FIFO_DEPTH));
    assign push   = rd_valid;
    assign pop    = m_tvalid && m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        start_xfer = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    start_xfer = 1'b1;
                end
            end
            RUN: begin
                if (pop && m_tlast) state_next = DONE;
            end
            DONE: begin
                if (!start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read issue, BRAM latency tracking, prefetch FIFO and beat accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_en    <= 1'b0;
            bram_addr  <= '0;
            rd_idx     <= '0;
            rd_valid   <= 1'b0;
            beat_cnt   <= '0;
            thr_q      <= '0;
            bin_q      <= 1'b0;
            edge_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
        end else begin
            bram_en  <= issue;
            rd_valid <= bram_en;
            if (issue) begin
                bram_addr <= 32'({rd_idx, 2'b00});
                rd_idx    <= rd_idx + IDX_W'(1);
            end

            if (push) begin
                fifo_mem[wr_ptr] <= bram_dout[7:0];
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (start_xfer) begin
                thr_q      <= threshold;
                bin_q      <= bin_en;
                edge_count <= '0;
                rd_idx     <= '0;
                beat_cnt   <= '0;
            end else if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                beat_cnt <= beat_cnt + IDX_W'(1);
                if ((head >= thr_q) && (edge_count != 16'hFFFF)) begin
                    edge_count <= edge_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer: a table of stream scenarios checked beat by beat
// against a reference BRAM image where pixel[i] = i[7:0].
module tb_conv_result_streamer;

    localparam int N = 900;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        done;
    logic [7:0]  threshold;
    logic        bin_en;
    logic [31:0] bram_addr;
    logic        bram_en;
    logic [31:0] bram_dout = '0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [15:0] edge_count;

    conv_result_streamer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .done       (done),
        .threshold  (threshold),
        .bin_en     (bin_en),
        .bram_addr  (bram_addr),
        .bram_en    (bram_en),
        .bram_dout  (bram_dout),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .edge_count (edge_count)
    );

    always #5 clk = ~clk;

    // BRAM image: low bits carry the pixel index, upper bits are junk the DUT must ignore.
    always @(posedge clk) begin
        if (bram_en) bram_dout <= {16'hDEAD, 6'h00, bram_addr[11:2]};
    end

    typedef struct {
        logic [7:0] thr;
        logic       bin;
        logic       stall;
        logic       hold;
        int         abort_at;
        int         exp_ec;
    } vec_t;

    vec_t vecs [8];
    int   tests = 0;
    int   fails = 0;
    int   cur_row = 0;
    logic stall_mode = 1'b0;
    int   stall_left = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL row%0d %s: got %0d expected %0d", cur_row, name, act, exp);
        end
    endtask

    // Sink ready: always 1, or random with occasional 20-cycle stalls.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!stall_mode) begin
                m_tready = 1'b1;
            end else if (stall_left > 0) begin
                m_tready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 39) == 0) begin
                m_tready   = 1'b0;
                stall_left = 19;
            end else begin
                m_tready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    task automatic check_all_zero();
        check("rst bram_addr", bram_addr, 0);
        check("rst bram_en", bram_en, 0);
        check("rst m_tvalid", m_tvalid, 0);
        check("rst m_tdata", m_tdata, 0);
        check("rst m_tlast", m_tlast, 0);
        check("rst done", done, 0);
        check("rst edge_count", edge_count, 0);
    endtask

    task automatic run_stream(input vec_t v, output bit aborted);
        int cyc, beats, first_v, last_cyc, done_cyc, issued, accepted, max_out;
        logic [7:0] p, exp_d, prev_d;
        logic prev_l, prev_stall;
        beats = 0; first_v = -1; last_cyc = -1; done_cyc = -1;
        issued = 0; accepted = 0; max_out = 0; prev_stall = 1'b0;
        prev_d = '0; prev_l = 1'b0; aborted = 1'b0;
        stall_mode = v.stall;
        threshold  = v.thr;
        bin_en     = v.bin;
        start      = 1'b1;
        for (cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                check("edge_count cleared", edge_count, 0);
                threshold = ~v.thr;
                bin_en    = ~v.bin;
                if (!v.hold) start = 1'b0;
            end
            if (bram_en) begin
                check("bram_addr", bram_addr, issued * 4);
                issued++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (prev_stall) begin
                check("stall tvalid", m_tvalid, 1);
                check("stall tdata", m_tdata, prev_d);
                check("stall tlast", m_tlast, prev_l);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            prev_l     = m_tlast;
            if (m_tvalid && first_v < 0) first_v = cyc;
            if (m_tvalid && m_tready) begin
                p     = 8'(beats);
                exp_d = v.bin ? ((p >= v.thr) ? 8'hFF : 8'h00) : p;
                check("tdata", m_tdata, exp_d);
                check("tlast", m_tlast, (beats == N - 1) ? 1 : 0);
                if (beats == N - 1) last_cyc = cyc;
                beats++;
                accepted++;
                if (v.abort_at > 0 && beats == v.abort_at) begin
                    rst_n = 1'b0;
                    start = 1'b0;
                    stall_mode = 1'b0;
                    #1;
                    check_all_zero();
                    aborted = 1'b1;
                    break;
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (aborted) return;
        check("done seen", (done_cyc >= 0) ? 1 : 0, 1);
        check("beat count", beats, N);
        check("first tvalid cycle", first_v, 3);
        check("done after last", done_cyc, last_cyc + 1);
        check("edge_count", edge_count, v.exp_ec);
        check("max outstanding", max_out, v.stall ? 4 : 3);
        if (!v.stall) check("last beat cycle", last_cyc, N + 2);
    endtask

    initial begin
        bit ab;
        rst_n     = 1'b0;
        start     = 1'b0;
        threshold = 8'h00;
        bin_en    = 1'b0;
        // thr, bin, stall, hold, abort_at, expected edge_count
        vecs[0] = '{8'd200, 1'b0, 1'b0, 1'b0, 0,   168};
        vecs[1] = '{8'd128, 1'b1, 1'b0, 1'b0, 0,   388};
        vecs[2] = '{8'd200, 1'b0, 1'b1, 1'b0, 0,   168};
        vecs[3] = '{8'd50,  1'b0, 1'b0, 1'b1, 0,   700};
        vecs[4] = '{8'd128, 1'b1, 1'b0, 1'b0, 400, 0};
        vecs[5] = '{8'd128, 1'b0, 1'b0, 1'b0, 0,   388};
        vecs[6] = '{8'd0,   1'b1, 1'b0, 1'b0, 0,   900};
        vecs[7] = '{8'd255, 1'b1, 1'b1, 1'b0, 0,   3};

        repeat (3) @(negedge clk);
        check_all_zero();
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            cur_row = i;
            run_stream(vecs[i], ab);
            if (ab) begin
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("idle after reset", done, 0);
            end else begin
                if (vecs[i].hold) begin
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        check("done held", done, 1);
                    end
                    start = 1'b0;
                end
                @(negedge clk);
                check("done drops", done, 0);
                check("edge_count held", edge_count, vecs[i].exp_ec);
                check("tvalid idle", m_tvalid, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
